// File: rtl/axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_mem_slave
// Brief    : AXI4 burst slave backed by a word-addressed on-chip RAM; write and
//            read channels run as independent FSMs over one shared array.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_mem_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH_WORDS  = 64
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IDW    = C_S_AXI_ID_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = $clog2(C_MEM_DEPTH_WORDS);

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] addr,
                                                  input logic [7:0]    len,
                                                  input logic [1:0]    burst);
        logic [AW-1:0] len_ext;
        logic [AW-1:0] mask;
        len_ext = {{(AW-8){1'b0}}, len};
        mask    = ((len_ext + 1'b1) << 2) - 1'b1;
        case (burst)
            2'b00:   f_next_addr = addr;
            2'b10:   f_next_addr = (addr & ~mask) | ((addr + 3'd4) & mask);
            default: f_next_addr = addr + 3'd4;
        endcase
    endfunction

    function automatic logic f_bad_req(input logic [2:0] size,
                                       input logic [7:0] len,
                                       input logic [1:0] burst);
        logic wrap_len_bad;
        wrap_len_bad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        f_bad_req = (size != 3'b010) || (burst == 2'b11) || (burst == 2'b10 && wrap_len_bad);
    endfunction

    logic [DW-1:0] r_mem [C_MEM_DEPTH_WORDS];

    // ------------------------------------------------------------------ write
    logic [1:0]     r_wstate;
    logic [1:0]     w_wstate_nxt;
    logic [IDW-1:0] r_wid;
    logic [AW-1:0]  r_waddr;
    logic [7:0]     r_wlen;
    logic [7:0]     r_wcnt;
    logic [1:0]     r_wburst;
    logic           r_werr;
    logic           w_aw_fire;
    logic           w_w_fire;

    always_comb begin
        w_wstate_nxt  = r_wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (r_wstate)
            c_W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) w_wstate_nxt = c_W_DATA;
            end
            c_W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && r_wcnt == r_wlen) w_wstate_nxt = c_W_RESP;
            end
            c_W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_wstate_nxt = c_W_IDLE;
            end
            default: w_wstate_nxt = c_W_IDLE;
        endcase
    end

    assign w_aw_fire   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_fire    = S_AXI_WVALID && S_AXI_WREADY;
    assign S_AXI_BID   = r_wid;
    assign S_AXI_BRESP = {r_werr & S_AXI_BVALID, 1'b0};

    always_ff @(posedge ACLK) begin
        if (ARESET) r_wstate <= c_W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
        end else begin
            if (w_aw_fire) begin
                r_wid    <= S_AXI_AWID;
                r_waddr  <= S_AXI_AWADDR;
                r_wlen   <= S_AXI_AWLEN;
                r_wburst <= S_AXI_AWBURST;
                r_wcnt   <= '0;
                r_werr   <= f_bad_req(S_AXI_AWSIZE, S_AXI_AWLEN, S_AXI_AWBURST);
            end
            if (w_w_fire) begin
                r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
                r_wcnt  <= r_wcnt + 8'd1;
                // A misplaced WLAST poisons the response but the beat count still rules.
                if (S_AXI_WLAST != (r_wcnt == r_wlen)) r_werr <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET && w_w_fire && !r_werr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b])
                    r_mem[r_waddr[2 +: IDX_W]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    logic [0:0]     r_rstate;
    logic [0:0]     w_rstate_nxt;
    logic [AW-1:0]  r_raddr;
    logic [AW-1:0]  w_raddr_nxt;
    logic [7:0]     r_rlen;
    logic [7:0]     r_rcnt;
    logic [1:0]     r_rburst;
    logic           r_rerr;
    logic [IDW-1:0] r_rid;
    logic [DW-1:0]  r_rdata;
    logic           r_rlast;
    logic           w_ar_fire;
    logic           w_r_fire;

    always_comb begin
        w_rstate_nxt  = r_rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_rstate)
            c_R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) w_rstate_nxt = c_R_DATA;
            end
            c_R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY && r_rlast) w_rstate_nxt = c_R_IDLE;
            end
            default: w_rstate_nxt = c_R_IDLE;
        endcase
    end

    assign w_ar_fire   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_r_fire    = S_AXI_RVALID && S_AXI_RREADY;
    assign w_raddr_nxt = f_next_addr(r_raddr, r_rlen, r_rburst);
    assign S_AXI_RID   = r_rid;
    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_RLAST = r_rlast;
    assign S_AXI_RRESP = {r_rerr & S_AXI_RVALID, 1'b0};

    always_ff @(posedge ACLK) begin
        if (ARESET) r_rstate <= c_R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    // The RAM read here sees the pre-write value when a write hits the same word.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rburst <= '0;
            r_rerr   <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rlast  <= 1'b0;
        end else if (w_ar_fire) begin
            r_rid    <= S_AXI_ARID;
            r_raddr  <= S_AXI_ARADDR;
            r_rlen   <= S_AXI_ARLEN;
            r_rburst <= S_AXI_ARBURST;
            r_rcnt   <= '0;
            r_rlast  <= (S_AXI_ARLEN == 8'd0);
            r_rerr   <= f_bad_req(S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARBURST);
            r_rdata  <= f_bad_req(S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARBURST)
                        ? '0 : r_mem[S_AXI_ARADDR[2 +: IDX_W]];
        end else if (w_r_fire) begin
            if (r_rlast) begin
                r_rlast <= 1'b0;
            end else begin
                r_raddr <= w_raddr_nxt;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rlast <= (r_rcnt + 8'd1 == r_rlen);
                r_rdata <= r_rerr ? '0 : r_mem[w_raddr_nxt[2 +: IDX_W]];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_burst_mem_slave
// Brief    : Directed self-checking bench for axi4_burst_mem_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_mem_slave;

    logic        tb_ACLK;
    logic        tb_ARESET;
    logic [3:0]  tb_AWID;
    logic [31:0] tb_AWADDR;
    logic [7:0]  tb_AWLEN;
    logic [2:0]  tb_AWSIZE;
    logic [1:0]  tb_AWBURST;
    logic        tb_AWVALID;
    logic        tb_AWREADY;
    logic [31:0] tb_WDATA;
    logic [3:0]  tb_WSTRB;
    logic        tb_WLAST;
    logic        tb_WVALID;
    logic        tb_WREADY;
    logic [3:0]  tb_BID;
    logic [1:0]  tb_BRESP;
    logic        tb_BVALID;
    logic        tb_BREADY;
    logic [3:0]  tb_ARID;
    logic [31:0] tb_ARADDR;
    logic [7:0]  tb_ARLEN;
    logic [2:0]  tb_ARSIZE;
    logic [1:0]  tb_ARBURST;
    logic        tb_ARVALID;
    logic        tb_ARREADY;
    logic [3:0]  tb_RID;
    logic [31:0] tb_RDATA;
    logic [1:0]  tb_RRESP;
    logic        tb_RLAST;
    logic        tb_RVALID;
    logic        tb_RREADY;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];
    logic [31:0] t1   [16];

    axi4_burst_mem_slave dut (
        .ACLK          (tb_ACLK),
        .ARESET        (tb_ARESET),
        .S_AXI_AWID    (tb_AWID),
        .S_AXI_AWADDR  (tb_AWADDR),
        .S_AXI_AWLEN   (tb_AWLEN),
        .S_AXI_AWSIZE  (tb_AWSIZE),
        .S_AXI_AWBURST (tb_AWBURST),
        .S_AXI_AWVALID (tb_AWVALID),
        .S_AXI_AWREADY (tb_AWREADY),
        .S_AXI_WDATA   (tb_WDATA),
        .S_AXI_WSTRB   (tb_WSTRB),
        .S_AXI_WLAST   (tb_WLAST),
        .S_AXI_WVALID  (tb_WVALID),
        .S_AXI_WREADY  (tb_WREADY),
        .S_AXI_BID     (tb_BID),
        .S_AXI_BRESP   (tb_BRESP),
        .S_AXI_BVALID  (tb_BVALID),
        .S_AXI_BREADY  (tb_BREADY),
        .S_AXI_ARID    (tb_ARID),
        .S_AXI_ARADDR  (tb_ARADDR),
        .S_AXI_ARLEN   (tb_ARLEN),
        .S_AXI_ARSIZE  (tb_ARSIZE),
        .S_AXI_ARBURST (tb_ARBURST),
        .S_AXI_ARVALID (tb_ARVALID),
        .S_AXI_ARREADY (tb_ARREADY),
        .S_AXI_RID     (tb_RID),
        .S_AXI_RDATA   (tb_RDATA),
        .S_AXI_RRESP   (tb_RRESP),
        .S_AXI_RLAST   (tb_RLAST),
        .S_AXI_RVALID  (tb_RVALID),
        .S_AXI_RREADY  (tb_RREADY)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; a VALID/READY pair seen high there fires on the next rise.
    task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [3:0] strb, input int bdelay, input logic [1:0] exp_resp);
        int n;
        @(negedge tb_ACLK);
        tb_AWID = id; tb_AWADDR = addr; tb_AWLEN = len; tb_AWSIZE = size; tb_AWBURST = burst;
        tb_AWVALID = 1'b1;
        n = 0;
        while (!tb_AWREADY && n < 50) begin @(negedge tb_ACLK); n++; end
        if (n >= 50) check_val({tag, "_aw_timeout"}, 32'd1, 32'd0);
        @(negedge tb_ACLK);
        tb_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            tb_WDATA = wbuf[i]; tb_WSTRB = strb; tb_WLAST = (i == int'(len)); tb_WVALID = 1'b1;
            n = 0;
            while (!tb_WREADY && n < 50) begin @(negedge tb_ACLK); n++; end
            if (n >= 50) check_val({tag, "_w_timeout"}, 32'd1, 32'd0);
            @(negedge tb_ACLK);
        end
        tb_WVALID = 1'b0; tb_WLAST = 1'b0;
        check_val({tag, "_wready_off"}, 32'(tb_WREADY), 32'd0);
        for (int k = 0; k < bdelay; k++) begin
            check_val({tag, "_hold_bvalid"}, 32'(tb_BVALID), 32'd1);
            check_val({tag, "_hold_awready"}, 32'(tb_AWREADY), 32'd0);
            check_val({tag, "_hold_bid"}, 32'(tb_BID), 32'(id));
            check_val({tag, "_hold_bresp"}, 32'(tb_BRESP), 32'(exp_resp));
            @(negedge tb_ACLK);
        end
        tb_BREADY = 1'b1;
        n = 0;
        while (!tb_BVALID && n < 50) begin @(negedge tb_ACLK); n++; end
        if (n >= 50) check_val({tag, "_b_timeout"}, 32'd1, 32'd0);
        check_val({tag, "_bid"}, 32'(tb_BID), 32'(id));
        check_val({tag, "_bresp"}, 32'(tb_BRESP), 32'(exp_resp));
        @(negedge tb_ACLK);
        tb_BREADY = 1'b0;
        check_val({tag, "_awready_back"}, 32'(tb_AWREADY), 32'd1);
        check_val({tag, "_bvalid_off"}, 32'(tb_BVALID), 32'd0);
    endtask

    task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input bit throttle,
                            input logic [1:0] exp_resp);
        int n;
        int cyc;
        int got;
        @(negedge tb_ACLK);
        tb_ARID = id; tb_ARADDR = addr; tb_ARLEN = len; tb_ARSIZE = 3'b010; tb_ARBURST = burst;
        tb_ARVALID = 1'b1;
        n = 0;
        while (!tb_ARREADY && n < 50) begin @(negedge tb_ACLK); n++; end
        if (n >= 50) check_val({tag, "_ar_timeout"}, 32'd1, 32'd0);
        @(negedge tb_ACLK);
        tb_ARVALID = 1'b0;
        got = 0;
        cyc = 0;
        while (got <= int'(len) && cyc < 200) begin
            tb_RREADY = throttle ? (cyc % 2 == 1) : 1'b1;
            if (tb_RVALID && tb_RREADY) begin
                check_val($sformatf("%s_data%0d", tag, got), tb_RDATA, rexp[got]);
                check_val($sformatf("%s_last%0d", tag, got), 32'(tb_RLAST), 32'(got == int'(len)));
                check_val($sformatf("%s_resp%0d", tag, got), 32'(tb_RRESP), 32'(exp_resp));
                check_val($sformatf("%s_id%0d", tag, got), 32'(tb_RID), 32'(id));
                got++;
            end
            @(negedge tb_ACLK);
            cyc++;
        end
        tb_RREADY = 1'b0;
        check_val({tag, "_beats"}, 32'(got), 32'(int'(len) + 1));
        check_val({tag, "_rvalid_off"}, 32'(tb_RVALID), 32'd0);
        check_val({tag, "_arready_back"}, 32'(tb_ARREADY), 32'd1);
    endtask

    initial begin
        int n;
        tb_ARESET = 1'b1;
        tb_AWID = '0; tb_AWADDR = '0; tb_AWLEN = '0; tb_AWSIZE = 3'b010; tb_AWBURST = 2'b01; tb_AWVALID = 1'b0;
        tb_WDATA = '0; tb_WSTRB = '0; tb_WLAST = 1'b0; tb_WVALID = 1'b0; tb_BREADY = 1'b0;
        tb_ARID = '0; tb_ARADDR = '0; tb_ARLEN = '0; tb_ARSIZE = 3'b010; tb_ARBURST = 2'b01; tb_ARVALID = 1'b0;
        tb_RREADY = 1'b0;
        for (int i = 0; i < 16; i++) t1[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        t1[0]  = 32'hFFFF_FFFF;
        t1[15] = 32'h00AB_CDEF;
        repeat (3) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        tb_ARESET = 1'b0;

        check_val("rst_awready", 32'(tb_AWREADY), 32'd1);
        check_val("rst_arready", 32'(tb_ARREADY), 32'd1);
        check_val("rst_wready", 32'(tb_WREADY), 32'd0);
        check_val("rst_bvalid", 32'(tb_BVALID), 32'd0);
        check_val("rst_rvalid", 32'(tb_RVALID), 32'd0);
        check_val("rst_rlast", 32'(tb_RLAST), 32'd0);
        check_val("rst_rdata", tb_RDATA, 32'd0);
        check_val("rst_ids", {24'd0, tb_BID, tb_RID}, 32'd0);
        check_val("rst_resps", {28'd0, tb_BRESP, tb_RRESP}, 32'd0);

        // 16-beat INCR write, then WRAP-16 read of the same block
        for (int i = 0; i < 16; i++) wbuf[i] = t1[i];
        axi_write("t1w", 4'd1, 32'h0, 8'd15, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        for (int i = 0; i < 16; i++) rexp[i] = t1[i];
        axi_read("t1r", 4'd2, 32'h0, 8'd15, 2'b10, 1'b0, 2'b00);

        // WRAP-4 starting mid-window
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        axi_write("t2w", 4'd3, 32'h0, 8'd3, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
        axi_read("t2r", 4'd4, 32'h8, 8'd3, 2'b10, 1'b0, 2'b00);

        // byte strobes, with B held off for 5 cycles
        wbuf[0] = 32'hFFFF_FFFF;
        axi_write("t3a", 4'd6, 32'h10, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        wbuf[0] = 32'h1122_3344;
        axi_write("t3b", 4'd7, 32'h10, 8'd0, 3'b010, 2'b01, 4'b0101, 5, 2'b00);
        rexp[0] = 32'hFF22_FF44;
        axi_read("t3r", 4'd8, 32'h10, 8'd0, 2'b01, 1'b0, 2'b00);

        // throttled RREADY over an INCR-8 read
        rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
        rexp[4] = 32'hFF22_FF44; rexp[5] = t1[5]; rexp[6] = t1[6]; rexp[7] = t1[7];
        axi_read("t4r", 4'd9, 32'h0, 8'd7, 2'b01, 1'b1, 2'b00);

        // illegal size on write: SLVERR and memory untouched
        wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'hCAFE_F00D;
        axi_write("t5w", 4'd10, 32'h20, 8'd1, 3'b001, 2'b01, 4'hF, 0, 2'b10);
        rexp[0] = t1[8]; rexp[1] = t1[9];
        axi_read("t5r", 4'd11, 32'h20, 8'd1, 2'b01, 1'b0, 2'b00);
        // WRAP with LEN=2 is illegal: three zero beats with SLVERR
        rexp[0] = 32'h0; rexp[1] = 32'h0; rexp[2] = 32'h0;
        axi_read("t5e", 4'd12, 32'h0, 8'd2, 2'b10, 1'b0, 2'b10);

        // reset pulse during beat 5 of a 16-beat read
        @(negedge tb_ACLK);
        tb_ARID = 4'd5; tb_ARADDR = 32'h0; tb_ARLEN = 8'd15; tb_ARSIZE = 3'b010; tb_ARBURST = 2'b01;
        tb_ARVALID = 1'b1;
        n = 0;
        while (!tb_ARREADY && n < 50) begin @(negedge tb_ACLK); n++; end
        if (n >= 50) check_val("t6_ar_timeout", 32'd1, 32'd0);
        @(negedge tb_ACLK);
        tb_ARVALID = 1'b0;
        tb_RREADY = 1'b1;
        repeat (4) @(negedge tb_ACLK);
        tb_RREADY = 1'b0;
        check_val("t6_beat5_data", tb_RDATA, 32'hFF22_FF44);
        tb_ARESET = 1'b1;
        @(negedge tb_ACLK);
        tb_ARESET = 1'b0;
        check_val("t6_rvalid", 32'(tb_RVALID), 32'd0);
        check_val("t6_arready", 32'(tb_ARREADY), 32'd1);
        check_val("t6_rlast", 32'(tb_RLAST), 32'd0);
        rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
        axi_read("t6r", 4'd13, 32'h8, 8'd3, 2'b10, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
